// File: rtl/argmax_pkg.sv
// Shared types and constants for the streaming argmax unit.
// Holds the FSM state encoding, the result index width and a width helper.
package argmax_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   localparam int IDX_W = 32;

   // Bits needed to hold values 0..value-1, never less than 1.
   function automatic int clog2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/argmax_lane_reduce.sv
// Combinational LANES-wide maximum over one element group.
// Masked lanes never win; on equal values the lower lane (lower index) is kept.
module argmax_lane_reduce
   import argmax_pkg::*;
#(
   parameter int LANES       = 2,
   parameter int INPUT_WIDTH = 16,
   parameter int SIGNED_CMP  = 1
) (
   input  logic [LANES*INPUT_WIDTH-1:0] i_vals,
   input  logic [LANES-1:0]             i_mask,
   input  logic [IDX_W-1:0]             i_base,
   output logic [INPUT_WIDTH-1:0]       o_val,
   output logic [IDX_W-1:0]             o_idx,
   output logic                         o_any
);

   logic [INPUT_WIDTH-1:0] lane_v;
   logic [INPUT_WIDTH-1:0] best_v;
   logic [IDX_W-1:0]       best_i;
   logic                   any_v;

   function automatic logic gt(input logic [INPUT_WIDTH-1:0] a,
                               input logic [INPUT_WIDTH-1:0] b);
      if (SIGNED_CMP != 0) return $signed(a) > $signed(b);
      else                 return a > b;
   endfunction

   // Priority chain from lane 0 upward: strict greater-than keeps the lower index on ties.
   always_comb begin
      lane_v = '0;
      best_v = '0;
      best_i = '0;
      any_v  = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         lane_v = i_vals[l*INPUT_WIDTH +: INPUT_WIDTH];
         if (i_mask[l] && (!any_v || gt(lane_v, best_v))) begin
            best_v = lane_v;
            best_i = i_base + IDX_W'(l);
            any_v  = 1'b1;
         end
      end
   end

   assign o_val = best_v;
   assign o_idx = best_i;
   assign o_any = any_v;

endmodule

// File: rtl/argmax_stream.sv
// Streaming argmax: captures one score vector, scans it LANES elements per cycle,
// and presents the winning index/value under a ready/valid handshake.
module argmax_stream
   import argmax_pkg::*;
#(
   parameter int NUM_INPUT   = 10,
   parameter int INPUT_WIDTH = 16,
   parameter int LANES       = 2,
   parameter int SIGNED_CMP  = 1
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic [NUM_INPUT*INPUT_WIDTH-1:0] i_data,
   input  logic                             i_valid,
   output logic                             o_ready,
   output logic [IDX_W-1:0]                 o_data,
   output logic [INPUT_WIDTH-1:0]           o_max,
   output logic                             o_data_valid,
   input  logic                             i_out_ready
);

   localparam int PTR_W = clog2(NUM_INPUT + LANES);
   localparam int W     = INPUT_WIDTH;

   state_e           state_q, state_d;
   logic [W-1:0]     buf_q [NUM_INPUT];
   logic [W-1:0]     buf_d [NUM_INPUT];
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [W-1:0]     best_val_q, best_val_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;
   logic             ready_q, ready_d;
   logic             dvalid_q, dvalid_d;
   logic [IDX_W-1:0] out_idx_q, out_idx_d;
   logic [W-1:0]     out_max_q, out_max_d;

   logic [LANES*W-1:0] lane_vals;
   logic [LANES-1:0]   lane_mask;
   logic [W-1:0]       win_val;
   logic [IDX_W-1:0]   win_idx;
   logic               win_any;
   logic               win_gt;
   logic               last_grp;

   function automatic logic gt(input logic [W-1:0] a, input logic [W-1:0] b);
      if (SIGNED_CMP != 0) return $signed(a) > $signed(b);
      else                 return a > b;
   endfunction

   // Gather elements ptr..ptr+LANES-1; lanes past the end of the vector stay masked.
   always_comb begin
      lane_vals = '0;
      lane_mask = '0;
      for (int l = 0; l < LANES; l++) begin
         for (int k = 0; k < NUM_INPUT; k++) begin
            if (IDX_W'(ptr_q) + IDX_W'(l) == IDX_W'(k)) begin
               lane_vals[l*W +: W] = buf_q[k];
               lane_mask[l]        = 1'b1;
            end
         end
      end
   end

   argmax_lane_reduce #(
      .LANES      (LANES),
      .INPUT_WIDTH(W),
      .SIGNED_CMP (SIGNED_CMP)
   ) u_reduce (
      .i_vals(lane_vals),
      .i_mask(lane_mask),
      .i_base(IDX_W'(ptr_q)),
      .o_val (win_val),
      .o_idx (win_idx),
      .o_any (win_any)
   );

   assign win_gt   = win_any && gt(win_val, best_val_q);
   assign last_grp = (IDX_W'(ptr_q) + IDX_W'(LANES)) >= IDX_W'(NUM_INPUT);

   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      ptr_d      = ptr_q;
      best_val_d = best_val_q;
      best_idx_d = best_idx_q;
      ready_d    = ready_q;
      dvalid_d   = dvalid_q;
      out_idx_d  = out_idx_q;
      out_max_d  = out_max_q;
      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               for (int k = 0; k < NUM_INPUT; k++) buf_d[k] = i_data[k*W +: W];
               best_val_d = i_data[W-1:0];
               best_idx_d = '0;
               ptr_d      = PTR_W'(1);
               ready_d    = 1'b0;
               state_d    = (NUM_INPUT == 1) ? ST_HOLD : ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (win_gt) begin
               best_val_d = win_val;
               best_idx_d = win_idx;
            end
            ptr_d = ptr_q + PTR_W'(LANES);
            if (last_grp) begin
               out_idx_d = win_gt ? win_idx : best_idx_q;
               out_max_d = win_gt ? win_val : best_val_q;
               dvalid_d  = 1'b1;
               state_d   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // A single-element vector arrives here with no result loaded yet.
            if (!dvalid_q) begin
               out_idx_d = best_idx_q;
               out_max_d = best_val_q;
               dvalid_d  = 1'b1;
            end else if (i_out_ready) begin
               dvalid_d = 1'b0;
               ready_d  = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         for (int k = 0; k < NUM_INPUT; k++) buf_q[k] <= '0;
         ptr_q      <= '0;
         best_val_q <= '0;
         best_idx_q <= '0;
         ready_q    <= 1'b1;
         dvalid_q   <= 1'b0;
         out_idx_q  <= '0;
         out_max_q  <= '0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         ptr_q      <= ptr_d;
         best_val_q <= best_val_d;
         best_idx_q <= best_idx_d;
         ready_q    <= ready_d;
         dvalid_q   <= dvalid_d;
         out_idx_q  <= out_idx_d;
         out_max_q  <= out_max_d;
      end
   end

   assign o_ready      = ready_q;
   assign o_data       = out_idx_q;
   assign o_max        = out_max_q;
   assign o_data_valid = dvalid_q;

endmodule

// File: tb/tb_argmax_stream.sv
// Directed bench for argmax_stream: default configuration plus unsigned,
// single-element and 7x3-lane instances, with hand-computed expectations.
module tb_argmax_stream;

   logic clk;
   logic rst;

   // Default instance: 10 x 16, LANES=2, signed.
   logic [159:0] data;
   logic         valid;
   logic         out_ready;
   logic         o_ready;
   logic [31:0]  o_data;
   logic [15:0]  o_max;
   logic         o_dv;

   // Extra parameter corners; result side always ready.
   logic         x_out_ready;
   logic [159:0] uns_data;
   logic         uns_valid, uns_ready, uns_dv;
   logic [31:0]  uns_idx;
   logic [15:0]  uns_max;
   logic [15:0]  n1_data;
   logic         n1_valid, n1_ready, n1_dv;
   logic [31:0]  n1_idx;
   logic [15:0]  n1_max;
   logic [111:0] n7_data;
   logic         n7_valid, n7_ready, n7_dv;
   logic [31:0]  n7_idx;
   logic [15:0]  n7_max;

   int n_checks;
   int n_err;

   argmax_stream u_dut (
      .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
      .o_ready(o_ready), .o_data(o_data), .o_max(o_max),
      .o_data_valid(o_dv), .i_out_ready(out_ready)
   );

   argmax_stream #(.SIGNED_CMP(0)) u_uns (
      .i_clk(clk), .i_rst(rst), .i_data(uns_data), .i_valid(uns_valid),
      .o_ready(uns_ready), .o_data(uns_idx), .o_max(uns_max),
      .o_data_valid(uns_dv), .i_out_ready(x_out_ready)
   );

   argmax_stream #(.NUM_INPUT(1), .LANES(1)) u_n1 (
      .i_clk(clk), .i_rst(rst), .i_data(n1_data), .i_valid(n1_valid),
      .o_ready(n1_ready), .o_data(n1_idx), .o_max(n1_max),
      .o_data_valid(n1_dv), .i_out_ready(x_out_ready)
   );

   argmax_stream #(.NUM_INPUT(7), .LANES(3)) u_n7 (
      .i_clk(clk), .i_rst(rst), .i_data(n7_data), .i_valid(n7_valid),
      .o_ready(n7_ready), .o_data(n7_idx), .o_max(n7_max),
      .o_data_valid(n7_dv), .i_out_ready(x_out_ready)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [159:0] pack10(input int e[10]);
      logic [159:0] r;
      r = '0;
      for (int k = 0; k < 10; k++) r[k*16 +: 16] = 16'(e[k]);
      return r;
   endfunction

   // Send one vector to the default instance, check latency, result and
   // (when hold > 0) stability under backpressure with an ignored i_valid pulse.
   task automatic run_vec(input string tag, input logic [159:0] vec,
                          input logic [31:0] exp_idx, input logic [15:0] exp_max,
                          input int hold);
      int  n;
      int  lat;
      bit  rdy_seen;
      n = 0;
      out_ready = (hold == 0);
      while (!o_ready && n < 50) begin
         tick();
         n++;
      end
      check_eq({tag, "_rdy_in"}, 32'(o_ready), 32'd1);
      data  = vec;
      valid = 1'b1;
      tick();
      valid = 1'b0;
      lat = 0;
      rdy_seen = 1'b0;
      while (!o_dv && lat < 50) begin
         rdy_seen |= o_ready;
         tick();
         lat++;
      end
      rdy_seen |= o_ready;
      check_eq({tag, "_lat"}, 32'(lat), 32'd5);
      check_eq({tag, "_rdy_low"}, 32'(rdy_seen), 32'd0);
      check_eq({tag, "_idx"}, o_data, exp_idx);
      check_eq({tag, "_max"}, 32'(o_max), 32'(exp_max));
      for (int h = 0; h < hold; h++) begin
         if (h == 1) begin
            data  = pack10('{500, 500, 500, 500, 500, 500, 500, 500, 500, 500});
            valid = 1'b1;
         end else begin
            valid = 1'b0;
         end
         tick();
         check_eq({tag, "_hold_idx"}, o_data, exp_idx);
         check_eq({tag, "_hold_max"}, 32'(o_max), 32'(exp_max));
         check_eq({tag, "_hold_dv"}, 32'(o_dv), 32'd1);
         check_eq({tag, "_hold_rdy"}, 32'(o_ready), 32'd0);
      end
      valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check_eq({tag, "_post_dv"}, 32'(o_dv), 32'd0);
      check_eq({tag, "_post_rdy"}, 32'(o_ready), 32'd1);
      check_eq({tag, "_post_idx"}, o_data, exp_idx);
   endtask

   // Fire the three corner instances together and record each one's first result.
   task automatic run_extras();
      int lat_u, lat_1, lat_7;
      logic [31:0] idx_u, idx_1, idx_7;
      logic [15:0] max_u, max_1, max_7;
      lat_u = 0; lat_1 = 0; lat_7 = 0;
      idx_u = '0; idx_1 = '0; idx_7 = '0;
      max_u = '0; max_1 = '0; max_7 = '0;
      uns_data = pack10('{-32768, 0, 0, 0, 1, 0, 0, 0, 0, 0});
      n1_data  = 16'hABCD;
      n7_data  = {16'd77, 16'd6, 16'd5, 16'd50, 16'd3, 16'd50, 16'hFFFF};
      uns_valid = 1'b1;
      n1_valid  = 1'b1;
      n7_valid  = 1'b1;
      tick();
      uns_valid = 1'b0;
      n1_valid  = 1'b0;
      n7_valid  = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (uns_dv && lat_u == 0) begin lat_u = c; idx_u = uns_idx; max_u = uns_max; end
         if (n1_dv && lat_1 == 0)  begin lat_1 = c; idx_1 = n1_idx;  max_1 = n1_max;  end
         if (n7_dv && lat_7 == 0)  begin lat_7 = c; idx_7 = n7_idx;  max_7 = n7_max;  end
      end
      check_eq("uns_lat", 32'(lat_u), 32'd5);
      check_eq("uns_idx", idx_u, 32'd0);
      check_eq("uns_max", 32'(max_u), 32'h8000);
      check_eq("n1_lat", 32'(lat_1), 32'd1);
      check_eq("n1_idx", idx_1, 32'd0);
      check_eq("n1_max", 32'(max_1), 32'hABCD);
      check_eq("n7_lat", 32'(lat_7), 32'd2);
      check_eq("n7_idx", idx_7, 32'd6);
      check_eq("n7_max", 32'(max_7), 32'd77);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit dv_seen;
      n_checks    = 0;
      n_err       = 0;
      rst         = 1'b1;
      data        = '0;
      valid       = 1'b0;
      out_ready   = 1'b1;
      x_out_ready = 1'b1;
      uns_data    = '0;
      uns_valid   = 1'b0;
      n1_data     = '0;
      n1_valid    = 1'b0;
      n7_data     = '0;
      n7_valid    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("rst_ready", 32'(o_ready), 32'd1);
      check_eq("rst_dv", 32'(o_dv), 32'd0);
      check_eq("rst_idx", o_data, 32'd0);
      check_eq("rst_max", 32'(o_max), 32'd0);

      run_vec("basic", pack10('{5, 3, 9, 1, 0, 2, 8, 4, 6, 7}), 32'd2, 16'd9, 0);
      run_vec("neg", pack10('{-100, -3, -50, -7, -9, -200, -4, -60, -8, -5}), 32'd1, 16'hFFFD, 0);
      run_vec("sgn", pack10('{-32768, 0, 0, 0, 1, 0, 0, 0, 0, 0}), 32'd4, 16'd1, 0);
      run_vec("tie_grp", pack10('{0, 0, 0, 7, 7, 0, 0, 0, 0, 0}), 32'd3, 16'd7, 0);
      run_vec("tie_run", pack10('{7, 0, 0, 0, 0, 0, 7, 0, 0, 0}), 32'd0, 16'd7, 0);
      run_vec("bp", pack10('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10}), 32'd9, 16'd10, 4);
      run_vec("after_bp", pack10('{0, 0, 0, 0, 0, 0, 0, 0, 42, 0}), 32'd8, 16'd42, 0);

      // Reset two cycles into SCAN: result registers clear and no result appears.
      data  = pack10('{1, 1, 1, 1, 1, 1, 1, 1, 99, 1});
      valid = 1'b1;
      tick();
      valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check_eq("mid_rst_ready", 32'(o_ready), 32'd1);
      check_eq("mid_rst_dv", 32'(o_dv), 32'd0);
      check_eq("mid_rst_idx", o_data, 32'd0);
      check_eq("mid_rst_max", 32'(o_max), 32'd0);
      tick();
      rst = 1'b0;
      dv_seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         dv_seen |= o_dv;
         tick();
      end
      check_eq("mid_rst_no_dv", 32'(dv_seen), 32'd0);
      run_vec("fresh", pack10('{3, 1, 4, 1, 5, 9, 2, 6, 5, 3}), 32'd5, 16'd9, 0);

      run_extras();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
